// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The controller side takes the master modport; the stage side takes slave.
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        ex_is_load_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic        id_reg1_read_i;
    logic        id_reg2_read_i;
    logic [4:0]  id_reg1_addr_i;
    logic [4:0]  id_reg2_addr_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic        wdog_o;

    modport master (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  ex_is_load_i, ex_wreg_i, ex_wd_i,
        input  id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
        input  excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, wdog_o
    );

    modport slave (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output ex_is_load_i, ex_wreg_i, ex_wd_i,
        output id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
        output excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, wdog_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: merges stall requests, detects
// load-use hazards, arbitrates against exceptions and keeps perf counters/watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e,
    parameter logic [15:0] WDOG_MAX   = 16'd1023
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e      state_q, state_d;
    logic        lu;
    logic        id_req;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic [15:0] wcnt_q;
    logic        wdog_q;

    assign lu = bus.ex_is_load_i & bus.ex_wreg_i & (bus.ex_wd_i != 5'd0) &
                ((bus.id_reg1_read_i & (bus.id_reg1_addr_i == bus.ex_wd_i)) |
                 (bus.id_reg2_read_i & (bus.id_reg2_addr_i == bus.ex_wd_i)));

    // ID holds a flushed bubble right after a flush, so its request is moot.
    assign id_req = (bus.stallreq_id_i | lu) & (state_q != StFlush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StRun;
        if (flush) begin
            state_d = StFlush;
        end else if (stall != 6'd0) begin
            state_d = StStall;
        end
    end

    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'd0;
        if (rst) begin
            stall  = 6'b000000;
        end else if (bus.excepttype_i != 32'd0) begin
            flush  = 1'b1;
            new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
        end else if (bus.stallreq_mem_i) begin
            stall = 6'b011111;
        end else if (bus.stallreq_ex_i) begin
            stall = 6'b001111;
        end else if (id_req) begin
            stall = 6'b000111;
        end else if (bus.stallreq_if_i) begin
            stall = 6'b000011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall != 6'd0) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    // wcnt counts the current stall run; the trip cycle is the WDOG_MAX-th one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= 16'd0;
            wdog_q <= 1'b0;
        end else if (stall != 6'd0) begin
            if (wcnt_q != 16'hFFFF) begin
                wcnt_q <= wcnt_q + 16'd1;
            end
            if (wcnt_q == (WDOG_MAX - 16'd1)) begin
                wdog_q <= 1'b1;
            end
        end else begin
            wcnt_q <= 16'd0;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.new_pc_o    = new_pc;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
    assign bus.wdog_o      = wdog_q;

endmodule
